ysyx_25020037_rd_xbar: RTL
==========================

// Module: ysyx_25020037_rd_xbar
// PURPOSE
//  AXI4 read-channel router between the core's LSU read port and two read slaves: the CLINT (mtime) and the SoC bus.
//  Decodes araddr, forwards AR to exactly one slave and returns its R beats unchanged. One transaction in flight.
//  Rejects multi-beat CLINT reads locally with SLVERR; the CLINT returns only single beats.
// PARAMETERS
//  CLINT_BASE  32'h0200_0000  first byte address of the CLINT window
//  CLINT_SIZE  32'h0001_0000  CLINT window size in bytes; window is [BASE, BASE+SIZE)
// PORTS
//  clk                               in   1   clock
//  rst_n                             in   1   asynchronous reset, active-low
//  s_arvalid / s_arready             in/out 1 upstream AR handshake
//  s_araddr,s_arid,s_arlen           in   32,4,8  upstream AR address, ID, beats-1
//  s_arsize,s_arburst                in   3,2  upstream AR size, burst type
//  s_rvalid / s_rready               out/in 1 upstream R handshake
//  s_rdata,s_rresp,s_rid,s_rlast     out  32,2,4,1  upstream R payload
//  clint_arvalid / clint_arready     out/in 1 CLINT AR handshake
//  clint_{araddr,arid,arlen,arsize,arburst} out 32,4,8,3,2  CLINT AR payload
//  clint_rvalid / clint_rready       in/out 1 CLINT R handshake
//  clint_{rdata,rresp,rid,rlast}     in   32,2,4,1  CLINT R payload
//  soc_* (same 13 signals as clint_*) out/in  SoC AR/R channel, identical widths
// BEHAVIOUR
//  FSM states IDLE, AR, DATA, ERR; reset -> IDLE. Async reset clears state and every output register.
//  Reset values: s_arready=0, s_rvalid=0, s_rresp=0, s_rdata=0, s_rlast=0, s_rid=0, *_arvalid=0, *_rready=0.
//  s_arready is registered: it goes 1 on the first clk after rst_n deasserts, and whenever the FSM enters IDLE.
//  IDLE: accept on s_arvalid&s_arready. Latch addr/id/len/size/burst, sel=hit_clint, then drop s_arready.
//    hit_clint = (araddr - CLINT_BASE) < CLINT_SIZE, computed as an unsigned 32-bit subtract, so addresses below BASE miss.
//    hit_clint & arlen!=0 -> ERR. Otherwise -> AR.
//  AR: selected *_arvalid=1 with the latched payload; unselected arvalid=0. Payload is stable while valid.
//    Move to DATA on the cycle after *_arvalid&*_arready. The AR phase takes at least 1 cycle.
//  DATA: R path is combinational from the selected slave. s_rvalid=sel_rvalid, s_rdata/rresp/rid/rlast pass through.
//    sel_rready=s_rready; unselected rready=0. An R beat from the unselected slave is ignored and never acked.
//    On s_rvalid&s_rready&s_rlast -> IDLE and s_arready<=1. Non-last beats stay in DATA; no beat count is checked.
//  ERR: local response with s_rvalid=1, s_rresp=2'b10, s_rdata=0, s_rlast=1, s_rid=latched id. Hold until s_rready, then IDLE.
//  Minimum latency is s_ar accept -> slave arvalid 1 cycle, plus the slave's own latency. No R-path bubble is added.
//  arlen wrap: 8'hFF is a legal 256-beat SoC burst and is forwarded untouched.
//  Back-to-back: a new AR is accepted no earlier than the cycle after the last R handshake.
//  Reset mid-operation: the FSM returns to IDLE and slave valid/ready drop immediately. Slaves are reset on the same rst_n.
//  Write channels are not routed by this block.
// STRUCTURE
//  Shared header ysyx_25020037_defines.vh holds the CLINT_BASE/SIZE defaults, the state encodings and RESP_OKAY/RESP_SLVERR.
//  Sub-module ysyx_25020037_rd_dec: combinational address decoder (addr -> hit_clint), reused later by the write xbar.
//  The top holds the FSM, the AR latch and the R mux.
// TESTING
//  1. rst_n low 3 cycles, then high -> all outputs 0 during reset; s_arready=1 on the first clk after release.
//  2. AR 0x0200_0000 len0 -> clint_arvalid 1 cycle later, soc_arvalid stays 0; CLINT rdata=mtimel, OKAY, rlast -> s_r matches, then IDLE.
//  3. AR 0x8000_0000 len3 INCR -> soc_arvalid; 4 SoC beats with s_rready toggling -> all 4 delivered in order, IDLE only after rlast.
//  4. AR 0x0200_0004 len1 -> no clint_arvalid; s_rresp=2'b10, s_rdata=0, s_rlast=1, s_rid=arid.
//  5. AR 0x01FF_FFFC and 0x0201_0000 -> both routed to the SoC (window boundary miss).
//  6. Pull rst_n low in DATA mid-burst -> clint/soc rready and arvalid drop asynchronously; the next AR after release routes correctly.

Source files
------------

// File: rtl/ysyx_25020037_rd_xbar_pkg.sv
// Shared definitions for the LSU read crossbar: CLINT window defaults, response codes,
// FSM state encoding and the latched AR request record.
package ysyx_25020037_rd_xbar_pkg;

  localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
  localparam logic [31:0] CLINT_SIZE_DEF = 32'h0001_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } rd_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_req_t;

  // Unsigned wrap-around subtract: addresses below base become huge and miss.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    logic [31:0] w_off;
    w_off = addr - base;
    return (w_off < size);
  endfunction

endpackage

// File: rtl/ysyx_25020037_rd_xbar_dec.sv
// Combinational address decoder: flags addresses inside the CLINT window.
// Kept separate so the write crossbar can reuse the same decode.
module ysyx_25020037_rd_dec
  import ysyx_25020037_rd_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DEF
) (
  input  logic [31:0] i_addr,
  output logic        o_hit_clint
);

  assign o_hit_clint = addr_in_window(i_addr, CLINT_BASE, CLINT_SIZE);

endmodule

// File: rtl/ysyx_25020037_rd_xbar.sv
// AXI4 read router: LSU read port -> CLINT or SoC bus, one transaction in flight.
// Multi-beat CLINT reads are answered locally with a single SLVERR beat.
module ysyx_25020037_rd_xbar
  import ysyx_25020037_rd_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  // upstream (LSU)
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [3:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic [3:0]  s_rid,
  output logic        s_rlast,
  // CLINT
  output logic        clint_arvalid,
  input  logic        clint_arready,
  output logic [31:0] clint_araddr,
  output logic [3:0]  clint_arid,
  output logic [7:0]  clint_arlen,
  output logic [2:0]  clint_arsize,
  output logic [1:0]  clint_arburst,
  input  logic        clint_rvalid,
  output logic        clint_rready,
  input  logic [31:0] clint_rdata,
  input  logic [1:0]  clint_rresp,
  input  logic [3:0]  clint_rid,
  input  logic        clint_rlast,
  // SoC bus
  output logic        soc_arvalid,
  input  logic        soc_arready,
  output logic [31:0] soc_araddr,
  output logic [3:0]  soc_arid,
  output logic [7:0]  soc_arlen,
  output logic [2:0]  soc_arsize,
  output logic [1:0]  soc_arburst,
  input  logic        soc_rvalid,
  output logic        soc_rready,
  input  logic [31:0] soc_rdata,
  input  logic [1:0]  soc_rresp,
  input  logic [3:0]  soc_rid,
  input  logic        soc_rlast,
  // debug
  output logic [1:0]  dbg_state
);

  // Handshake rule on every channel: a transfer happens on the rising clk edge
  // where valid and ready are both high; valid never waits for ready, and the
  // payload is held stable while valid is high and ready is low.

  rd_state_e r_state;
  ar_req_t   r_req;
  logic      r_sel_clint;
  logic      r_s_arready;
  logic      r_clint_arvalid;
  logic      r_soc_arvalid;

  logic        w_hit_clint;
  logic        w_ar_accept;
  logic        w_sel_ar_hs;
  logic        w_s_rvalid;
  logic [31:0] w_s_rdata;
  logic [1:0]  w_s_rresp;
  logic [3:0]  w_s_rid;
  logic        w_s_rlast;
  logic        w_clint_rready;
  logic        w_soc_rready;

  ysyx_25020037_rd_dec #(
    .CLINT_BASE (CLINT_BASE),
    .CLINT_SIZE (CLINT_SIZE)
  ) u_dec (
    .i_addr      (s_araddr),
    .o_hit_clint (w_hit_clint)
  );

  assign w_ar_accept = s_arvalid & r_s_arready;
  assign w_sel_ar_hs = r_sel_clint ? (r_clint_arvalid & clint_arready)
                                   : (r_soc_arvalid & soc_arready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_req           <= '0;
      r_sel_clint     <= 1'b0;
      r_s_arready     <= 1'b0;
      r_clint_arvalid <= 1'b0;
      r_soc_arvalid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ar_accept) begin
            r_req.addr  <= s_araddr;
            r_req.id    <= s_arid;
            r_req.len   <= s_arlen;
            r_req.size  <= s_arsize;
            r_req.burst <= s_arburst;
            r_sel_clint <= w_hit_clint;
            r_s_arready <= 1'b0;
            if (w_hit_clint && (s_arlen != 8'd0)) begin
              r_state <= ST_ERR;
            end else begin
              r_state         <= ST_AR;
              r_clint_arvalid <= w_hit_clint;
              r_soc_arvalid   <= ~w_hit_clint;
            end
          end else begin
            // Also covers the first cycle after reset release.
            r_s_arready <= 1'b1;
          end
        end
        ST_AR: begin
          if (w_sel_ar_hs) begin
            r_clint_arvalid <= 1'b0;
            r_soc_arvalid   <= 1'b0;
            r_state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_s_rvalid && s_rready && w_s_rlast) begin
            r_state     <= ST_IDLE;
            r_s_arready <= 1'b1;
          end
        end
        ST_ERR: begin
          if (s_rready) begin
            r_state     <= ST_IDLE;
            r_s_arready <= 1'b1;
          end
        end
        default: begin
          r_state         <= ST_IDLE;
          r_s_arready     <= 1'b0;
          r_clint_arvalid <= 1'b0;
          r_soc_arvalid   <= 1'b0;
        end
      endcase
    end
  end

  // R path is combinational so no bubble is added; outside DATA/ERR it is all zero.
  always_comb begin
    w_s_rvalid     = 1'b0;
    w_s_rdata      = 32'd0;
    w_s_rresp      = RESP_OKAY;
    w_s_rid        = 4'd0;
    w_s_rlast      = 1'b0;
    w_clint_rready = 1'b0;
    w_soc_rready   = 1'b0;
    case (r_state)
      ST_DATA: begin
        if (r_sel_clint) begin
          w_s_rvalid     = clint_rvalid;
          w_s_rdata      = clint_rdata;
          w_s_rresp      = clint_rresp;
          w_s_rid        = clint_rid;
          w_s_rlast      = clint_rlast;
          w_clint_rready = s_rready;
        end else begin
          w_s_rvalid     = soc_rvalid;
          w_s_rdata      = soc_rdata;
          w_s_rresp      = soc_rresp;
          w_s_rid        = soc_rid;
          w_s_rlast      = soc_rlast;
          w_soc_rready   = s_rready;
        end
      end
      ST_ERR: begin
        w_s_rvalid = 1'b1;
        w_s_rresp  = RESP_SLVERR;
        w_s_rid    = r_req.id;
        w_s_rlast  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign s_arready     = r_s_arready;
  assign s_rvalid      = w_s_rvalid;
  assign s_rdata       = w_s_rdata;
  assign s_rresp       = w_s_rresp;
  assign s_rid         = w_s_rid;
  assign s_rlast       = w_s_rlast;

  assign clint_arvalid = r_clint_arvalid;
  assign clint_araddr  = r_req.addr;
  assign clint_arid    = r_req.id;
  assign clint_arlen   = r_req.len;
  assign clint_arsize  = r_req.size;
  assign clint_arburst = r_req.burst;
  assign clint_rready  = w_clint_rready;

  assign soc_arvalid   = r_soc_arvalid;
  assign soc_araddr    = r_req.addr;
  assign soc_arid      = r_req.id;
  assign soc_arlen     = r_req.len;
  assign soc_arsize    = r_req.size;
  assign soc_arburst   = r_req.burst;
  assign soc_rready    = w_soc_rready;

  assign dbg_state     = r_state;

endmodule
